// File: rtl/mem_req_pkg.sv
// mem_req_pkg: shared definitions for the data-memory request queue and its
// alignment helper.
//   SIZE_B/SIZE_H/SIZE_W : access size encodings (3 is illegal and treated as a word)
//   entry_t              : per-entry control state of the queue
//   misalign()           : alignment check for a size / low-address pair
//   norm_size()          : folds the illegal size 3 onto word
package mem_req_pkg;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   // Tag and data are kept in separate arrays in the queue because the tag
   // width is a parameter of the queue instance.
   typedef struct packed {
      logic       valid;
      logic       done;
      logic       cancel;
      logic       wr;
      logic [1:0] size;
      logic       sext;
      logic [1:0] off;
   } entry_t;

   function automatic logic [1:0] norm_size(input logic [1:0] size);
      return (size == 2'd3) ? SIZE_W : size;
   endfunction

   function automatic logic misalign(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      case (norm_size(size))
         SIZE_B:  bad = 1'b0;
         SIZE_H:  bad = off[0];
         default: bad = |off;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_data_align.sv
// mem_data_align: combinational byte-lane formatting for 32-bit data accesses.
//   store_size/store_off/store_src -> store_strb, store_data (replicated lanes)
//   load_size/load_off/load_sext/load_raw -> load_data (shifted and extended)
// The store and load sides are independent so one instance can format an
// outgoing request while extracting the data of an older returning load.
module mem_data_align
   import mem_req_pkg::*;
(
   input  logic [1:0]  store_size,
   input  logic [1:0]  store_off,
   input  logic [31:0] store_src,
   output logic [3:0]  store_strb,
   output logic [31:0] store_data,
   input  logic [1:0]  load_size,
   input  logic [1:0]  load_off,
   input  logic        load_sext,
   input  logic [31:0] load_raw,
   output logic [31:0] load_data
);

   logic [31:0] shifted;

   always_comb begin
      store_strb = 4'b1111;
      store_data = store_src;
      case (norm_size(store_size))
         SIZE_B: begin
            store_strb = 4'b0001 << store_off;
            store_data = {4{store_src[7:0]}};
         end
         SIZE_H: begin
            store_strb = store_off[1] ? 4'b1100 : 4'b0011;
            store_data = {2{store_src[15:0]}};
         end
         default: ;
      endcase
   end

   // Bring the addressed byte/half down to bit 0 before extending.
   assign shifted = load_raw >> {load_off, 3'b000};

   always_comb begin
      load_data = load_raw;
      case (norm_size(load_size))
         SIZE_B:  load_data = {{24{load_sext & shifted[7]}},  shifted[7:0]};
         SIZE_H:  load_data = {{16{load_sext & shifted[15]}}, shifted[15:0]};
         default: load_data = load_raw;
      endcase
   end

endmodule

// File: rtl/mem_req_queue.sv
// mem_req_queue: in-order data-memory access unit between EXE and MEM.
// Issues SRAM-like requests (req/addr_ok, then data_ok) with up to DEPTH
// transactions outstanding or buffered, and returns responses in order.
//   clk, reset                : clock, synchronous active-high reset
//   req_*                     : EXE memory op; req_ready = accepted this cycle
//   flush                     : cancel all undelivered ops, block issue this cycle
//   ale                       : current op is misaligned (not issued)
//   sram_*                    : bus request / completion
//   rsp_*                     : in-order responses to MEM (rsp_data 0 for stores)
//   busy                      : any entry allocated, cancelled ones included
module mem_req_queue
   import mem_req_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 32,
   parameter int TAG_W  = 5
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [1:0]        req_size,
   input  logic              req_sext,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [TAG_W-1:0]  req_tag,
   input  logic              flush,
   output logic              ale,
   output logic              sram_req,
   output logic              sram_wr,
   output logic [1:0]        sram_size,
   output logic [3:0]        sram_wstrb,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_wdata,
   input  logic              sram_addr_ok,
   input  logic              sram_data_ok,
   input  logic [31:0]       sram_rdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_wr,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic [31:0]       rsp_data,
   output logic              busy
);

   localparam int             PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL    = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   entry_t            ent   [DEPTH];
   logic [TAG_W-1:0]  tags  [DEPTH];
   logic [31:0]       datas [DEPTH];

   // tail: next slot to allocate, fill: oldest op awaiting data_ok,
   // head: oldest op awaiting delivery. count separates full from empty.
   logic [PTR_W-1:0]  head, fill, tail;
   logic [PTR_W:0]    count;

   logic              alloc, fill_en, pop;
   logic [3:0]        store_strb;
   logic [31:0]       store_data;
   logic [31:0]       load_data;

   // ---------------- issue side ----------------
   assign ale       = req_valid & misalign(req_size, req_addr[1:0]);
   // Registered count only: a pop in this cycle frees its slot next cycle.
   assign sram_req  = req_valid & ~ale & ~flush & (count < FULL);
   assign req_ready = sram_req & sram_addr_ok;
   assign alloc     = req_ready;

   assign sram_wr    = req_wr;
   assign sram_size  = norm_size(req_size);
   assign sram_addr  = req_addr;
   assign sram_wstrb = req_wr ? store_strb : 4'b0000;
   assign sram_wdata = store_data;

   mem_data_align u_align (
      .store_size (req_size),
      .store_off  (req_addr[1:0]),
      .store_src  (req_wdata),
      .store_strb (store_strb),
      .store_data (store_data),
      .load_size  (ent[fill].size),
      .load_off   (ent[fill].off),
      .load_sext  (ent[fill].sext),
      .load_raw   (sram_rdata),
      .load_data  (load_data)
   );

   // ---------------- completion / delivery ----------------
   // A data_ok with nothing outstanding is dropped rather than corrupting state.
   assign fill_en   = sram_data_ok & ent[fill].valid & ~ent[fill].done;

   assign rsp_valid = ent[head].valid & ent[head].done & ~ent[head].cancel;
   // Cancelled entries leave silently once the bus has completed them.
   assign pop       = ent[head].valid & ent[head].done & (ent[head].cancel | rsp_ready);

   assign rsp_wr    = ent[head].wr;
   assign rsp_tag   = tags[head];
   assign rsp_data  = datas[head];
   assign busy      = (count != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         fill  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      end else begin
         // Flush cannot coincide with alloc (issue is gated), so marking
         // every live entry here never misses a fresh one.
         for (int i = 0; i < DEPTH; i++) begin
            if (flush && ent[i].valid) ent[i].cancel <= 1'b1;
         end
         if (alloc) begin
            ent[tail] <= '{valid: 1'b1, done: 1'b0, cancel: 1'b0, wr: req_wr,
                           size: norm_size(req_size), sext: req_sext,
                           off: req_addr[1:0]};
            tail <= tail + PTR_ONE;
         end
         if (fill_en) begin
            ent[fill].done <= 1'b1;
            fill <= fill + PTR_ONE;
         end
         // Pop last so a flush in the delivery cycle leaves the slot clean.
         if (pop) begin
            ent[head] <= '0;
            head <= head + PTR_ONE;
         end
         count <= count + {{PTR_W{1'b0}}, alloc} - {{PTR_W{1'b0}}, pop};
      end
   end

   // Payload storage needs no reset: it is only read behind valid/done.
   always_ff @(posedge clk) begin
      if (alloc)   tags[tail]  <= req_tag;
      if (fill_en) datas[fill] <= ent[fill].wr ? 32'd0 : load_data;
   end

   data_ok_has_target: assert property (@(posedge clk) disable iff (reset)
      sram_data_ok |-> (ent[fill].valid && !ent[fill].done));

endmodule

// File: tb/tb_mem_req_queue.sv
module tb_mem_req_queue;

   localparam int DEPTH  = 2;
   localparam int ADDR_W = 32;
   localparam int TAG_W  = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid, req_ready, req_wr, req_sext, flush, ale;
   logic [1:0]        req_size;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic [TAG_W-1:0]  req_tag;
   logic              sram_req, sram_wr, sram_addr_ok, sram_data_ok;
   logic [1:0]        sram_size;
   logic [3:0]        sram_wstrb;
   logic [ADDR_W-1:0] sram_addr;
   logic [31:0]       sram_wdata, sram_rdata;
   logic              rsp_valid, rsp_ready, rsp_wr, busy;
   logic [TAG_W-1:0]  rsp_tag;
   logic [31:0]       rsp_data;

   always #5 clk = ~clk;

   mem_req_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_tag(req_tag), .flush(flush), .ale(ale),
      .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size),
      .sram_wstrb(sram_wstrb), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
      .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok),
      .sram_rdata(sram_rdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
      .rsp_tag(rsp_tag), .rsp_data(rsp_data), .busy(busy)
   );

   typedef struct packed {
      logic             wr;
      logic [TAG_W-1:0] tag;
      logic [31:0]      data;
   } rsp_t;

   rsp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic push(input logic wr, input logic [TAG_W-1:0] tag, input logic [31:0] data);
      rsp_t e;
      e.wr = wr; e.tag = tag; e.data = data;
      sb.push_back(e);
   endtask

   // Monitor: compares every delivered response against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && rsp_valid) begin
            if (sb.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_rsp: got tag %0d data 0x%08h, expected no response",
                        rsp_tag, rsp_data);
            end else if (rsp_ready) begin
               rsp_t e;
               e = sb.pop_front();
               chk1 ("rsp_wr",   rsp_wr, e.wr);
               chk32("rsp_tag",  32'(rsp_tag), 32'(e.tag));
               chk32("rsp_data", rsp_data, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic wr, input logic [1:0] size, input logic sext,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [TAG_W-1:0] tag);
      req_valid = 1'b1; req_wr = wr; req_size = size; req_sext = sext;
      req_addr = addr; req_wdata = wd; req_tag = tag;
   endtask

   // One op: issue with addr_ok, data_ok next cycle, response the cycle after.
   task automatic single(input string name, input logic wr, input logic [1:0] size,
                         input logic sext, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [TAG_W-1:0] tag, input logic [31:0] rdata,
                         input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_data);
      push(wr, tag, exp_data);
      drive(wr, size, sext, addr, wd, tag);
      @(negedge clk);
      chk1 ({name, "_req_ready"}, req_ready, 1'b1);
      chk1 ({name, "_sram_wr"}, sram_wr, wr);
      chk32({name, "_wstrb"}, 32'(sram_wstrb), 32'(exp_strb));
      if (wr) chk32({name, "_wdata"}, sram_wdata, exp_wdata);
      step();
      req_valid = 1'b0; sram_data_ok = 1'b1; sram_rdata = rdata;
      @(negedge clk);
      chk1({name, "_rsp_early"}, rsp_valid, 1'b0);
      step();
      sram_data_ok = 1'b0;
      @(negedge clk);
      chk1({name, "_rsp_valid"}, rsp_valid, 1'b1);
      step();
   endtask

   task automatic misal(input string name, input logic [1:0] size, input logic [31:0] addr);
      drive(1'b0, size, 1'b0, addr, 32'd0, 5'd31);
      @(negedge clk);
      chk1({name, "_ale"}, ale, 1'b1);
      chk1({name, "_sram_req"}, sram_req, 1'b0);
      chk1({name, "_req_ready"}, req_ready, 1'b0);
      step();
      req_valid = 1'b0;
      @(negedge clk);
      chk1({name, "_busy"}, busy, 1'b0);
      step();
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0; req_sext = 1'b0;
      req_addr = '0; req_wdata = '0; req_tag = '0; flush = 1'b0;
      sram_addr_ok = 1'b1; sram_data_ok = 1'b0; sram_rdata = '0; rsp_ready = 1'b1;
      step(); step();
      reset = 1'b0;
      @(negedge clk);
      chk1("reset_busy", busy, 1'b0);
      chk1("reset_rsp_valid", rsp_valid, 1'b0);
      chk1("reset_sram_req", sram_req, 1'b0);
      step();

      // Directed single ops
      single("st_w",  1'b1, 2'd2, 1'b0, 32'h1000, 32'h1234_5678, 5'd1, 32'h0,
             4'b1111, 32'h1234_5678, 32'h0);
      single("ldb_s", 1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 5'd2, 32'h80FF_0000,
             4'b0000, 32'h0, 32'hFFFF_FF80);
      single("ldb_u", 1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 5'd3, 32'h80FF_0000,
             4'b0000, 32'h0, 32'h0000_0080);
      misal("ldh_mis", 2'd1, 32'h1001);
      misal("ldw_mis", 2'd2, 32'h1002);
      misal("ld3_mis", 2'd3, 32'h1001);
      single("st_h",  1'b1, 2'd1, 1'b0, 32'h1002, 32'h0000_ABCD, 5'd4, 32'h0,
             4'b1100, 32'hABCD_ABCD, 32'h0);
      single("st_b",  1'b1, 2'd0, 1'b0, 32'h1001, 32'h0000_005A, 5'd5, 32'h0,
             4'b0010, 32'h5A5A_5A5A, 32'h0);
      single("ld_w",  1'b0, 2'd2, 1'b0, 32'h1004, 32'h0, 5'd6, 32'hDEAD_BEEF,
             4'b0000, 32'h0, 32'hDEAD_BEEF);

      // Full queue: third load stalls until a pop is registered
      rsp_ready = 1'b0;
      push(1'b0, 5'd1, 32'h0000_00A1);
      drive(1'b0, 2'd2, 1'b0, 32'h2000, 32'h0, 5'd1);
      @(negedge clk); chk1("full_req1", sram_req, 1'b1); step();
      push(1'b0, 5'd2, 32'h0000_00A2);
      drive(1'b0, 2'd2, 1'b0, 32'h2004, 32'h0, 5'd2);
      @(negedge clk); chk1("full_req2", sram_req, 1'b1); step();
      push(1'b0, 5'd3, 32'h0000_00A3);
      drive(1'b0, 2'd2, 1'b0, 32'h2008, 32'h0, 5'd3);
      sram_data_ok = 1'b1; sram_rdata = 32'h0000_00A1;
      @(negedge clk); chk1("full_req3_stall", sram_req, 1'b0); step();
      sram_rdata = 32'h0000_00A2;
      @(negedge clk);
      chk1("full_stall_b", sram_req, 1'b0);
      chk1("full_head_valid", rsp_valid, 1'b1);
      step();
      sram_data_ok = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); chk1("full_hold", sram_req, 1'b0); step();
      end
      rsp_ready = 1'b1;
      @(negedge clk); chk1("full_pop_cycle", sram_req, 1'b0); step();
      @(negedge clk); chk1("full_resume", sram_req, 1'b1); step();
      req_valid = 1'b0; sram_data_ok = 1'b1; sram_rdata = 32'h0000_00A3;
      @(negedge clk); step();
      sram_data_ok = 1'b0;
      @(negedge clk); chk1("full_last_rsp", rsp_valid, 1'b1); step();

      // Flush with two loads outstanding; next load returns normally
      drive(1'b0, 2'd2, 1'b0, 32'h3000, 32'h0, 5'd7);
      @(negedge clk); step();
      drive(1'b0, 2'd2, 1'b0, 32'h3004, 32'h0, 5'd8);
      @(negedge clk); step();
      req_valid = 1'b0; flush = 1'b1;
      @(negedge clk);
      chk1("flush_busy", busy, 1'b1);
      chk1("flush_no_req", sram_req, 1'b0);
      step();
      flush = 1'b0; sram_data_ok = 1'b1; sram_rdata = 32'h1111_1111;
      push(1'b0, 5'd9, 32'hFFFF_8001);
      drive(1'b0, 2'd1, 1'b1, 32'h300A, 32'h0, 5'd9);
      @(negedge clk);
      chk1("flush_full", sram_req, 1'b0);
      chk1("flush_dok1_rsp", rsp_valid, 1'b0);
      step();
      sram_rdata = 32'h2222_2222;
      @(negedge clk); chk1("flush_dok2_rsp", rsp_valid, 1'b0); step();
      sram_data_ok = 1'b0;
      @(negedge clk);
      chk1("flush_reissue", sram_req, 1'b1);
      chk1("flush_busy_tail", busy, 1'b1);
      step();
      req_valid = 1'b0; sram_data_ok = 1'b1; sram_rdata = 32'h8001_0000;
      @(negedge clk); chk1("flush_new_early", rsp_valid, 1'b0); step();
      sram_data_ok = 1'b0;
      @(negedge clk); chk1("flush_new_rsp", rsp_valid, 1'b1); step();
      @(negedge clk); chk1("flush_idle", busy, 1'b0); step();

      // Reset with two entries outstanding
      drive(1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 5'd10);
      @(negedge clk); step();
      drive(1'b0, 2'd2, 1'b0, 32'h4004, 32'h0, 5'd11);
      @(negedge clk); step();
      req_valid = 1'b0; reset = 1'b1;
      @(negedge clk); chk1("prereset_busy", busy, 1'b1); step();
      reset = 1'b0;
      @(negedge clk);
      chk1("midreset_busy", busy, 1'b0);
      chk1("midreset_rsp", rsp_valid, 1'b0);
      step();
      single("post_rst", 1'b0, 2'd2, 1'b0, 32'h4008, 32'h0, 5'd12, 32'h0BAD_F00D,
             4'b0000, 32'h0, 32'h0BAD_F00D);

      repeat (2) step();
      chk32("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_req_queue.md
# mem_req_queue

Parametrised in-order data-memory access unit between EXE and MEM. It issues SRAM-like requests (req/addr_ok, then data_ok) and keeps up to DEPTH transactions outstanding, instead of the single blocking access of the current stage. It flags misaligned accesses, formats store strobes and data, and extracts and extends load data. It also cancels in-flight transactions on pipeline flush without breaking the bus protocol.

## Interface
- DEPTH, 2: max transactions outstanding or buffered; power of 2, ≥2
- ADDR_W, 32: physical address width
- TAG_W, 5: opaque tag carried request→response (dest reg)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  EXE holds a memory op
- req_ready  out  1  op accepted this cycle (= sram_req & sram_addr_ok)
- req_wr  in  1  1 store, 0 load
- req_size  in  2  0 byte, 1 half, 2 word; 3 illegal (treated as word)
- req_sext  in  1  signed load (ld.b/ld.h)
- req_addr  in  ADDR_W  physical address
- req_wdata  in  32  unaligned store source (rkd)
- req_tag  in  TAG_W  tag
- flush  in  1  cancel all undelivered ops; block issue this cycle
- ale  out  1  req_valid & misaligned (comb.)
- sram_req  out  1  bus request
- sram_wr, sram_size[2], sram_wstrb[4], sram_addr[ADDR_W], sram_wdata[32]  out  bus request fields
- sram_addr_ok  in  1  address accepted
- sram_data_ok  in  1  oldest accepted op complete
- sram_rdata  in  32  load data
- rsp_valid  out  1  response at head
- rsp_ready  in  1  MEM consumes response
- rsp_wr, rsp_tag[TAG_W], rsp_data[32]  out  response fields (rsp_data 0 for stores)
- busy  out  1  any entry allocated (incl. cancelled)

## Operation
- Misaligned: size1 & addr[0], or size2 & |addr[1:0]. ale=1, sram_req=0, req_ready=0. EXE raises ALE.
- sram_req = req_valid & ~ale & ~flush & (count < DEPTH). count is the registered value; a same-cycle pop does not free a slot.
- Store: wstrb is byte→1<<addr[1:0], half→addr[1]?1100:0011, word→1111. wdata replicates {4{b}}, {2{h}}, or word. Loads drive wstrb 0 and sram_wr=0.
- Buffer: DEPTH entries {valid, done, cancel, wr, size, sext, off[1:0], tag, data}, with three wrapping pointers:
  - tail: alloc on addr_ok
  - fill: advances on data_ok and captures the extracted rdata
  - head: advances on pop
- Load extract: rdata>>(8*off), then byte/half sign- or zero-extend per sext; word unchanged.
- rsp_valid = head.valid & head.done & ~head.cancel. Pop when rsp_valid & rsp_ready, or when head is done & cancelled (auto-drop, no rsp_valid).
- flush sets cancel on every valid entry. Cancelled entries still consume data_ok, because the bus must complete them. An entry allocated in the flush cycle cannot exist, since issue is gated.
- busy = count != 0. The pipeline front end waits for !busy only when it requires a quiescent bus (ertn/exception refetch is not gated).
- data_ok with no undone entry is a protocol error. It is ignored, and simulation asserts.

## Timing
- Reset: pointers 0, count 0, all valid/done/cancel 0. Registered-derived outputs rsp_valid=0, busy=0. sram_req=0 unless req_valid.
- Issue latency 0: request visible the cycle req_valid rises if a slot is free.
- data_ok earliest cycle after addr_ok. Response rsp_valid earliest the cycle after data_ok (registered).
- Full (count==DEPTH): sram_req low until a pop is registered.
- Simultaneous alloc, fill and pop on three different entries are all legal in one cycle. count += alloc − pop.
- Wrap: pointers modulo DEPTH (log2 bits), and count disambiguates full and empty.
- Reset mid-transaction discards all entries. The bus is reset concurrently, so no late data_ok is expected.

## Structure
- Package mem_req_pkg: SIZE_B/SIZE_H/SIZE_W constants, entry struct typedef, and a misalign function.
- Sub-module mem_data_align (combinational): store wstrb/wdata generation and load extraction. Reused by the uncached path.

## Test plan
- Store word 0x12345678 to 0x1000, addr_ok same cycle, data_ok +1 → wstrb 1111, req_ready=1, rsp_valid at +2 with rsp_wr=1, rsp_data 0.
- ld.b addr 0x1003, rdata 0x80FF_0000, sext=1 → rsp_data 0xFFFF_FF80; same with sext=0 → 0x0000_0080.
- ld.h addr 0x1001 → ale=1, sram_req=0, no entry allocated; st.h addr 0x1002 data 0xABCD → wstrb 1100, wdata 0xABCD_ABCD.
- DEPTH=2: three back-to-back loads with data_ok held off → 3rd request stalls (sram_req=0) until first pop; rsp_ready held low → no further issue; order preserved by tag 1,2,3.
- Two loads outstanding, flush asserted, then data_ok ×2 → no rsp_valid, busy falls after 2nd data_ok; a load issued the cycle after flush returns normally.
- Reset asserted with 2 entries outstanding → next cycle busy=0, rsp_valid=0, count 0.
